// File: rtl/relu_tile_unpacker.sv
// relu_tile_unpacker: buffers one ROWSxCOLS tile and streams it
// out element by element in row-major order over valid/ready.
module relu_tile_unpacker #(
  parameter int ROWS = 3,
  parameter int COLS = 4,
  parameter int W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*COLS*W-1:0] in_tile,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic [1:0]             out_row,
  output logic [1:0]             out_col,
  output logic                   out_last,
  output logic                   busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [1:0] RMAX = 2'(ROWS - 1);
  localparam logic [1:0] CMAX = 2'(COLS - 1);

  state_t     state;
  state_t     state_nx;
  logic [W-1:0] elem [ROWS][COLS];
  logic [1:0] row;
  logic [1:0] col;
  logic       at_end;
  logic       accept;
  logic       xfer;

  assign at_end = (row == RMAX) && (col == CMAX);
  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state: leave STREAM only when the last beat goes with no new tile
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (accept) state_nx = STREAM;
      STREAM: if (xfer && at_end && !accept) state_nx = IDLE;
    endcase
  end

  // outputs: in STREAM a new tile may enter only as the last beat leaves
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_row   = 2'd0;
    out_col   = 2'd0;
    out_last  = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = !rst;
      end
      STREAM: begin
        in_ready  = at_end && out_ready && !rst;
        out_valid = 1'b1;
        out_data  = elem[row][col];
        out_row   = row;
        out_col   = col;
        out_last  = at_end;
        busy      = 1'b1;
      end
    endcase
  end

  // tile buffer and row/col position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= 2'd0;
      col <= 2'd0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          elem[i][j] <= '0;
    end else if (accept) begin
      row <= 2'd0;
      col <= 2'd0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          elem[i][j] <= in_tile[(i*COLS+j)*W +: W];
    end else if (xfer) begin
      if (at_end) begin
        row <= 2'd0;
        col <= 2'd0;
      end else if (col == CMAX) begin
        row <= row + 2'd1;
        col <= 2'd0;
      end else begin
        col <= col + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_relu_tile_unpacker.sv
// tb_relu_tile_unpacker: directed and random tiles checked against
// a queue of expected beats built from each accepted tile.
module tb_relu_tile_unpacker;

  localparam int ROWS = 3;
  localparam int COLS = 4;
  localparam int W    = 32;
  localparam int N    = ROWS * COLS;
  localparam int TW   = N * W;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   r;
    logic [1:0]   c;
    logic         last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_tile;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_row;
  logic [1:0]    out_col;
  logic          out_last;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  beat_t         q[$];
  logic          pend_v = 1'b0;
  logic [TW-1:0] pend_t = '0;
  int            mode   = 0;
  int            pcnt   = 0;

  relu_tile_unpacker #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_tile(in_tile),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // expected beats of a tile, row-major
  task automatic push_tile(logic [TW-1:0] t);
    for (int k = 0; k < N; k++) begin
      beat_t b;
      b.d    = t[k*W +: W];
      b.r    = 2'(k / COLS);
      b.c    = 2'(k % COLS);
      b.last = (k == N - 1);
      q.push_back(b);
    end
  endtask

  // one clock: drive, check at settle, update model on the edge
  task automatic cycle();
    logic ordy, ev, eir, acc, xf;
    case (mode)
      0:       ordy = 1'b1;
      1:       ordy = (pcnt % 3 == 0);
      default: ordy = 1'($urandom_range(0, 1));
    endcase
    pcnt++;
    in_valid  = pend_v;
    in_tile   = pend_v ? pend_t : {12{$urandom}};
    out_ready = ordy;
    #1;
    ev  = (q.size() != 0);
    eir = !ev || (q[0].last && ordy);
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, eir);
    chk("busy", busy, ev);
    if (ev) begin
      chk("out_data", out_data, q[0].d);
      chk("out_row", out_row, q[0].r);
      chk("out_col", out_col, q[0].c);
      chk("out_last", out_last, q[0].last);
    end else begin
      chk("out_last_idle", out_last, 1'b0);
    end
    acc = pend_v && eir;
    xf  = ev && ordy;
    @(posedge clk);
    if (xf) void'(q.pop_front());
    if (acc) begin
      push_tile(pend_t);
      pend_v = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic send(logic [TW-1:0] t);
    int n = 0;
    pend_t = t;
    pend_v = 1'b1;
    while (pend_v && n < 200) begin
      cycle();
      n++;
    end
    if (pend_v) begin
      chk("accept_timeout", 1'b0, 1'b1);
      pend_v = 1'b0;
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_out_data"}, out_data, '0);
    chk({tag, "_out_row"}, out_row, 2'd0);
    chk({tag, "_out_col"}, out_col, 2'd0);
    chk({tag, "_out_last"}, out_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  function automatic logic [TW-1:0] fill_all(logic [W-1:0] v);
    logic [TW-1:0] t;
    for (int k = 0; k < N; k++) t[k*W +: W] = v;
    return t;
  endfunction

  initial begin
    logic [TW-1:0] t;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_tile   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;
    @(negedge clk);

    // single tile k*10, always ready
    mode = 0;
    for (int k = 0; k < N; k++) t[k*W +: W] = W'(k * 10);
    send(t);
    run(N + 2);

    // backpressure 1,0,0 pattern
    mode = 1;
    pcnt = 0;
    send(t);
    run(3 * N + 3);

    // back-to-back: B held while A streams
    mode = 0;
    send(fill_all(32'd5));
    send(fill_all(32'd7));
    run(N + 2);

    // signed extremes pass through bit-exact
    for (int k = 0; k < N; k++) t[k*W +: W] = $urandom;
    t[0*W +: W] = 32'h7FFFFFFF;
    t[1*W +: W] = 32'h0;
    t[2*W +: W] = 32'h80000000;
    t[7*W +: W] = 32'hFFFFFFFF;
    send(t);
    run(N + 2);

    // mid-stream reset after five beats
    send(fill_all(32'hA5A5_0000));
    run(5);
    #2 rst = 1'b1;
    #1;
    reset_checks("midrst");
    q.delete();
    pend_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle();
    for (int k = 0; k < N; k++) t[k*W +: W] = W'(1000 + k);
    send(t);
    run(N + 2);

    // random tiles, random backpressure, garbage on in_tile
    mode = 2;
    for (int i = 0; i < 500; i++) begin
      if (!pend_v && $urandom_range(0, 3) == 0) begin
        for (int k = 0; k < N; k++) t[k*W +: W] = $urandom;
        if ($urandom_range(0, 1) == 1) t[0 +: W] = 32'h80000000;
        pend_t = t;
        pend_v = 1'b1;
      end
      cycle();
    end
    mode = 0;
    if (pend_v) send(pend_t);
    run(N + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
